// File: rtl/clint_ctrl.sv
// clint_ctrl: core-local interrupt controller front-end.
// Two requesters share one timer register file (msip, mtimecmp, mtime)
// through a round-robin arbiter and an IDLE/RESP access sequencer.
// Drives the machine timer (mtip) and software (msip) interrupt lines.
module clint_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_en,
    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic              m0_wen,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [63:0]       m0_wdata,
    input  logic [7:0]        m0_wmask,
    output logic              m0_rvalid,
    output logic [63:0]       m0_rdata,
    output logic              m0_err,
    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic              m1_wen,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [63:0]       m1_wdata,
    input  logic [7:0]        m1_wmask,
    output logic              m1_rvalid,
    output logic [63:0]       m1_rdata,
    output logic              m1_err,
    output logic              mtip,
    output logic              msip
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] OFF_MSIP     = ADDR_W'(16'h0000);
    localparam logic [ADDR_W-1:0] OFF_MTIMECMP = ADDR_W'(16'h4000);
    localparam logic [ADDR_W-1:0] OFF_MTIME    = ADDR_W'(16'hBFF8);
    localparam logic [15:0]       PRESC_MAX    = 16'(TICK_DIV - 1);

    // Per-byte merge of write data into an existing 64-bit register value.
    function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  mask);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

    state_t              state_r, state_s;
    logic                rr_r;
    logic                gnt_valid_s, gnt_port_s;
    logic [1:0]          ready_s;
    logic                sel_wen_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [63:0]         sel_wdata_s;
    logic [7:0]          sel_wmask_s;
    logic                hit_msip_s, hit_cmp_s, hit_time_s, mapped_s;
    logic [63:0]         read_val_s;
    logic                tick_s;
    logic                wr_msip_s, wr_cmp_s, wr_time_s;
    logic [1:0]          rvalid_r, err_r;
    logic [63:0]         rdata0_r, rdata1_r;
    logic [15:0]         presc_r;
    logic [63:0]         mtime_r, mtimecmp_r;
    logic                msip_r, mtip_r;
    logic                addr_unused_s;

    // Round-robin grant: the pointer port wins a tie, a lone requester always wins.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_port_s  = rr_r;
        if (state_r == ST_IDLE && !rst) begin
            case ({m1_valid, m0_valid})
                2'b01: begin gnt_valid_s = 1'b1; gnt_port_s = 1'b0; end
                2'b10: begin gnt_valid_s = 1'b1; gnt_port_s = 1'b1; end
                2'b11: begin gnt_valid_s = 1'b1; gnt_port_s = rr_r; end
                default: begin gnt_valid_s = 1'b0; gnt_port_s = rr_r; end
            endcase
        end else begin
            gnt_valid_s = 1'b0;
        end
    end

    assign ready_s = gnt_valid_s ? (gnt_port_s ? 2'b10 : 2'b01) : 2'b00;

    // Steer the granted request fields onto the shared register-file bus.
    always_comb begin
        sel_wen_s   = m0_wen;
        sel_addr_s  = m0_addr;
        sel_wdata_s = m0_wdata;
        sel_wmask_s = m0_wmask;
        if (gnt_port_s) begin
            sel_wen_s   = m1_wen;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
            sel_wmask_s = m1_wmask;
        end else begin
            sel_wen_s   = m0_wen;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
            sel_wmask_s = m0_wmask;
        end
    end

    // Offsets are 8-byte aligned, so the low three address bits are not decoded.
    assign addr_unused_s = ^sel_addr_s[2:0];
    assign hit_msip_s    = (sel_addr_s[ADDR_W-1:3] == OFF_MSIP[ADDR_W-1:3]);
    assign hit_cmp_s     = (sel_addr_s[ADDR_W-1:3] == OFF_MTIMECMP[ADDR_W-1:3]);
    assign hit_time_s    = (sel_addr_s[ADDR_W-1:3] == OFF_MTIME[ADDR_W-1:3]);
    assign mapped_s      = hit_msip_s | hit_cmp_s | hit_time_s;

    // Read mux returns the pre-write value; unmapped offsets read as zero.
    always_comb begin
        read_val_s = 64'd0;
        if (hit_msip_s) begin
            read_val_s = {63'd0, msip_r};
        end else if (hit_cmp_s) begin
            read_val_s = mtimecmp_r;
        end else if (hit_time_s) begin
            read_val_s = mtime_r;
        end else begin
            read_val_s = 64'd0;
        end
    end

    assign tick_s    = tick_en && (presc_r == PRESC_MAX);
    assign wr_msip_s = gnt_valid_s && sel_wen_s && hit_msip_s;
    assign wr_cmp_s  = gnt_valid_s && sel_wen_s && hit_cmp_s;
    assign wr_time_s = gnt_valid_s && sel_wen_s && hit_time_s;

    // Sequencer next state: an accepted request always gets one response cycle.
    always_comb begin
        state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: state_s = gnt_valid_s ? ST_RESP : ST_IDLE;
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer state and round-robin pointer; pointer moves off the port just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            rr_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            if (gnt_valid_s) begin
                rr_r <= ~gnt_port_s;
            end else begin
                rr_r <= rr_r;
            end
        end
    end

    // Response registers: load on accept, pulse rvalid/err for the following cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_r <= 2'b00;
            err_r    <= 2'b00;
            rdata0_r <= 64'd0;
            rdata1_r <= 64'd0;
        end else begin
            rvalid_r <= ready_s;
            err_r    <= mapped_s ? 2'b00 : ready_s;
            if (ready_s[0]) begin
                rdata0_r <= read_val_s;
            end else begin
                rdata0_r <= rdata0_r;
            end
            if (ready_s[1]) begin
                rdata1_r <= read_val_s;
            end else begin
                rdata1_r <= rdata1_r;
            end
        end
    end

    // Prescaler runs only while enabled and is not disturbed by mtime writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= 16'd0;
        end else if (tick_en) begin
            presc_r <= tick_s ? 16'd0 : presc_r + 16'd1;
        end else begin
            presc_r <= presc_r;
        end
    end

    // mtime: a bus write takes precedence and swallows a coincident increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_r <= 64'd0;
        end else if (wr_time_s) begin
            mtime_r <= merge_bytes(mtime_r, sel_wdata_s, sel_wmask_s);
        end else if (tick_s) begin
            mtime_r <= mtime_r + 64'd1;
        end else begin
            mtime_r <= mtime_r;
        end
    end

    // mtimecmp and msip byte-masked writes; msip keeps only bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp_r <= {64{1'b1}};
            msip_r     <= 1'b0;
        end else begin
            if (wr_cmp_s) begin
                mtimecmp_r <= merge_bytes(mtimecmp_r, sel_wdata_s, sel_wmask_s);
            end else begin
                mtimecmp_r <= mtimecmp_r;
            end
            if (wr_msip_s && sel_wmask_s[0]) begin
                msip_r <= sel_wdata_s[0];
            end else begin
                msip_r <= msip_r;
            end
        end
    end

    // Timer interrupt compare, re-evaluated every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtip_r <= 1'b0;
        end else begin
            mtip_r <= (mtime_r >= mtimecmp_r);
        end
    end

    // Responses are suppressed while reset is asserted, even mid-transaction.
    assign m0_ready  = ready_s[0];
    assign m1_ready  = ready_s[1];
    assign m0_rvalid = rvalid_r[0] & ~rst;
    assign m1_rvalid = rvalid_r[1] & ~rst;
    assign m0_err    = err_r[0] & ~rst;
    assign m1_err    = err_r[1] & ~rst;
    assign m0_rdata  = rdata0_r;
    assign m1_rdata  = rdata1_r;
    assign mtip      = mtip_r;
    assign msip      = msip_r;

endmodule
